store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Posted-write FIFO between the M-stage store-data formatter and the data-memory write port.
- Accepts one already-formatted store per cycle: word address, byte-lane-aligned write data, and 4-bit byte enable.
- Drains stores to memory through a valid/ready handshake.
- Merges same-word stores into the youngest pending entry, and flags loads that hit a pending store so the pipeline can stall.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); width of the read/write pointers.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 clears the buffer.
- st_valid  input  1  M stage presents a store this cycle.
- st_addr  input  32  store byte address; only [31:2] is used.
- st_wdata  input  32  lane-aligned store data.
- st_byteen  input  4  byte enables; 4'b0000 with st_valid=1 is ignored.
- st_stall  output  1  store cannot be accepted; upstream holds st_* and freezes.
- ld_valid  input  1  M stage presents a load this cycle.
- ld_addr  input  32  load byte address; only [31:2] is compared.
- ld_stall  output  1  load word matches a pending entry.
- mem_valid  output  1  head entry is presented to memory.
- mem_ready  input  1  memory accepts the head this cycle.
- mem_addr  output  32  {head word address, 2'b00}.
- mem_wdata  output  32  head data.
- mem_byteen  output  4  head byte enable.
- count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Storage: DEPTH entries, each holding {word_addr[29:0], data[31:0], byteen[3:0]}.
  - Pointers: rd_ptr and wr_ptr, PTR_W bits, wrap modulo DEPTH.
  - Occupancy counter: count, range 0..DEPTH.
- Reset (reset=0, asynchronous):
  - count=0, rd_ptr=0, wr_ptr=0, all entry byteen=0.
  - Outputs immediately: mem_valid=0, st_stall=0, ld_stall=0.
  - Pending stores are discarded, including an in-flight mem_valid&&!mem_ready head.
- Drain:
  - mem_valid = (count!=0). mem_addr, mem_wdata and mem_byteen are driven combinationally from entry[rd_ptr].
  - Dequeue occurs at a clock edge where mem_valid&&mem_ready: rd_ptr+1.
  - While mem_valid=1 and mem_ready=0, the head outputs must remain bit-stable.
- Merge condition: st_valid && st_byteen!=0 && count>=2 && entry[wr_ptr-1].word_addr==st_addr[31:2].
  - count>=2 guarantees the tail is never the presented head.
  - On merge, for each lane i with st_byteen[i]=1: tail data byte i <= st_wdata byte i, and tail byteen[i] <= 1.
  - Lanes with st_byteen[i]=0 keep their old byte and enable bit.
  - Pointers and count are unchanged by a merge.
- Enqueue condition: st_valid && st_byteen!=0 && !merge && count<DEPTH.
  - entry[wr_ptr] <= {st_addr[31:2], st_wdata, st_byteen}; wr_ptr+1.
- Stall outputs (combinational, no registered path):
  - st_stall = st_valid && st_byteen!=0 && !merge && count==DEPTH.
  - A full buffer does not accept a new entry even if a dequeue happens in the same cycle.
  - While stalled, the store is not captured.
- Count update on each edge: count <= count + enq - deq, where enq and deq are the enqueue and dequeue events above.
  - Simultaneous enq and deq: count unchanged, both pointers advance.
- Load check: ld_stall = ld_valid && some occupied entry k (from rd_ptr for count entries) has word_addr==ld_addr[31:2].
  - Byte enables are ignored in this comparison.
  - The incoming same-cycle store is not compared.
- st_valid and ld_valid are mutually exclusive by construction upstream. If both are 1, each side is evaluated independently as specified above.
- Latency:
  - A store accepted at edge N gives mem_valid=1 after edge N when the buffer was empty.
  - Minimum occupancy time is 1 cycle.

Test Plan:
- Reset then idle: reset=0 mid-cycle with count=3 -> mem_valid=0 and count=0 at once, with no clock needed; after reset=1 the outputs stay idle.
- Single store 0x0000_1004 / 0x1122_3344 / 4'b1111, mem_ready=0 for 3 cycles then 1:
  - mem_addr=0x0000_1004, mem_wdata=0x1122_3344 held stable throughout;
  - dequeue on the ready edge -> count=0.
- Fill: 5 back-to-back distinct-word stores with mem_ready=0 -> st_stall=1 on the 5th with count=4; after one mem_ready edge the 5th is accepted and count stays 4.
- Merge: stores to 0x100 then 0x200 (byteen 4'b0001, data 0x0000_00AA), then 0x200 (byteen 4'b0100, data 0x00BB_0000) -> count=2 and tail = 0x00BB_00AA / 4'b0101.
  - With count=1, the same sequence does not merge; it enqueues instead.
- Load hazard:
  - Pending store at 0x300, ld_addr=0x302 -> ld_stall=1.
  - ld_addr=0x304 -> ld_stall=0.
  - After the 0x300 entry drains, ld_addr=0x302 -> ld_stall=0.
- Wrap-around: 10 stores with mem_ready toggling every cycle -> memory receives all 10 in order with correct data, pointers wrap cleanly, and no entry is lost or duplicated.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// Store/load/memory handshake bundle for the posted store write buffer.
// slave = the buffer itself; master = the pipeline/memory environment around it.
interface store_write_buffer_if #(
    parameter int PTR_W = 2
);
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_wdata;
    logic [3:0]       st_byteen;
    logic             st_stall;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_stall;
    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_byteen;
    logic [PTR_W:0]   count;

    modport slave (
        input  st_valid, st_addr, st_wdata, st_byteen, ld_valid, ld_addr, mem_ready,
        output st_stall, ld_stall, mem_valid, mem_addr, mem_wdata, mem_byteen, count
    );

    modport master (
        output st_valid, st_addr, st_wdata, st_byteen, ld_valid, ld_addr, mem_ready,
        input  st_stall, ld_stall, mem_valid, mem_addr, mem_wdata, mem_byteen, count
    );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between store formatter and data memory, merging same-word stores into the tail.
// Latency: store visible on mem_* one edge after acceptance; backpressure: st_stall when full, head held while !mem_ready.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TWO_CNT  = (PTR_W+1)'(2);

    logic [29:0]      ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_be   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   count;

    logic st_req;
    logic merge;
    logic enq;
    logic deq;
    logic ld_hit;

    assign tail_ptr = wr_ptr - PTR_W'(1);
    assign st_req   = bus.st_valid && (bus.st_byteen != 4'b0000);
    // count>=2 keeps the merge target away from the head currently shown to memory
    assign merge    = st_req && (count >= TWO_CNT) && (ent_addr[tail_ptr] == bus.st_addr[31:2]);
    assign enq      = st_req && !merge && (count != FULL_CNT);
    assign deq      = bus.mem_valid && bus.mem_ready;

    assign bus.st_stall   = st_req && !merge && (count == FULL_CNT);
    assign bus.mem_valid  = (count != '0);
    assign bus.mem_addr   = {ent_addr[rd_ptr], 2'b00};
    assign bus.mem_wdata  = ent_data[rd_ptr];
    assign bus.mem_byteen = ent_be[rd_ptr];
    assign bus.count      = count;
    assign bus.ld_stall   = bus.ld_valid && ld_hit;

    always_comb begin
        logic [PTR_W-1:0] idx;
        ld_hit = 1'b0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (((PTR_W+1)'(k) < count) && (ent_addr[idx] == bus.ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent_addr[e] <= '0;
                ent_data[e] <= '0;
                ent_be[e]   <= '0;
            end
        end else begin
            if (merge) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.st_byteen[i]) begin
                        ent_data[tail_ptr][8*i +: 8] <= bus.st_wdata[8*i +: 8];
                        ent_be[tail_ptr][i]          <= 1'b1;
                    end
                end
            end
            if (enq) begin
                ent_addr[wr_ptr] <= bus.st_addr[31:2];
                ent_data[wr_ptr] <= bus.st_wdata;
                ent_be[wr_ptr]   <= bus.st_byteen;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (enq && !deq) begin
                count <= count + (PTR_W+1)'(1);
            end else if (deq && !enq) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: reset, drain hold, fill/stall, merge, load hazard, wrap-around.
module tb_store_write_buffer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    store_write_buffer_if #(.PTR_W(2)) bus ();

    store_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.st_valid  = 1'b1;
        bus.st_addr   = a;
        bus.st_wdata  = d;
        bus.st_byteen = be;
    endtask

    task automatic idle_store();
        bus.st_valid  = 1'b0;
        bus.st_byteen = 4'b0000;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_checks++;
        if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b want 0", bus.mem_valid); end
        n_checks++;
        if (bus.st_stall !== 1'b0 || bus.ld_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stalls: got st=%b ld=%b want 0/0", bus.st_stall, bus.ld_stall);
        end
        tick();
        reset = 1'b1;
        tick();
        // three stores pending, then an asynchronous mid-cycle reset
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h0000_0A00 + 32'(i * 4), 32'h1000 + 32'(i), 4'b1111);
            tick();
        end
        idle_store();
        #1;
        n_checks++;
        if (bus.count !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 3", bus.count); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_valid !== 1'b0 || bus.count !== 3'd0) begin
            n_fail++; $display("FAIL async_reset: got mem_valid=%b count=%0d want 0/0", bus.mem_valid, bus.count);
        end
        #1;
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.mem_valid !== 1'b0 || bus.count !== 3'd0) begin
            n_fail++; $display("FAIL post_reset_idle: got mem_valid=%b count=%0d want 0/0", bus.mem_valid, bus.count);
        end
    endtask

    task automatic test_single();
        drive_store(32'h0000_1004, 32'h1122_3344, 4'b1111);
        tick();
        idle_store();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h0000_1004 ||
                bus.mem_wdata !== 32'h1122_3344 || bus.mem_byteen !== 4'b1111) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: got v=%b a=%h d=%h be=%b want 1/00001004/11223344/1111",
                         c, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_byteen);
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 3'd0 || bus.mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got count=%0d v=%b want 0/0", bus.count, bus.mem_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h0000_2000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'b1111);
            tick();
        end
        drive_store(32'h0000_2010, 32'hC0DE_0004, 4'b1111);
        #1;
        n_checks++;
        if (bus.st_stall !== 1'b1 || bus.count !== 3'd4) begin
            n_fail++; $display("FAIL fill_stall: got stall=%b count=%0d want 1/4", bus.st_stall, bus.count);
        end
        // dequeue edge alone does not admit the held store
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 3'd3 || bus.st_stall !== 1'b0) begin
            n_fail++; $display("FAIL fill_deq: got count=%0d stall=%b want 3/0", bus.count, bus.st_stall);
        end
        tick();
        idle_store();
        #1;
        n_checks++;
        if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_accept: got count=%0d want 4", bus.count); end
        bus.mem_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            n_checks++;
            if (bus.mem_addr !== 32'h0000_2000 + 32'(i * 4) || bus.mem_wdata !== 32'hC0DE_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL fill_order[%0d]: got a=%h d=%h want %h/%h", i, bus.mem_addr, bus.mem_wdata,
                         32'h0000_2000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 3'd0) begin n_fail++; $display("FAIL fill_empty: got count=%0d want 0", bus.count); end
    endtask

    task automatic test_merge();
        drive_store(32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
        tick();
        drive_store(32'h0000_0200, 32'h0000_00AA, 4'b0001);
        tick();
        drive_store(32'h0000_0200, 32'h00BB_0000, 4'b0100);
        tick();
        idle_store();
        #1;
        n_checks++;
        if (bus.count !== 3'd2) begin n_fail++; $display("FAIL merge_count: got %0d want 2", bus.count); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_addr !== 32'h0000_0200 || bus.mem_wdata !== 32'h00BB_00AA || bus.mem_byteen !== 4'b0101) begin
            n_fail++;
            $display("FAIL merge_tail: got a=%h d=%h be=%b want 00000200/00bb00aa/0101",
                     bus.mem_addr, bus.mem_wdata, bus.mem_byteen);
        end
        bus.mem_ready = 1'b1;
        tick();
        // with only one entry pending the same-word store must enqueue
        drive_store(32'h0000_0200, 32'h0000_00AA, 4'b0001);
        bus.mem_ready = 1'b0;
        tick();
        drive_store(32'h0000_0200, 32'h00BB_0000, 4'b0100);
        tick();
        idle_store();
        #1;
        n_checks++;
        if (bus.count !== 3'd2 || bus.mem_wdata !== 32'h0000_00AA || bus.mem_byteen !== 4'b0001) begin
            n_fail++;
            $display("FAIL nomerge_head: got count=%0d d=%h be=%b want 2/000000aa/0001",
                     bus.count, bus.mem_wdata, bus.mem_byteen);
        end
        bus.mem_ready = 1'b1;
        tick();
        #1;
        n_checks++;
        if (bus.mem_wdata !== 32'h00BB_0000 || bus.mem_byteen !== 4'b0100) begin
            n_fail++; $display("FAIL nomerge_second: got d=%h be=%b want 00bb0000/0100", bus.mem_wdata, bus.mem_byteen);
        end
        tick();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 3'd0) begin n_fail++; $display("FAIL merge_empty: got count=%0d want 0", bus.count); end
    endtask

    task automatic test_load();
        drive_store(32'h0000_0300, 32'h1234_5678, 4'b0011);
        tick();
        drive_store(32'h0000_0400, 32'h8765_4321, 4'b1111);
        tick();
        idle_store();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_0302;
        #1;
        n_checks++;
        if (bus.ld_stall !== 1'b1) begin n_fail++; $display("FAIL ld_hit_head: got %b want 1", bus.ld_stall); end
        bus.ld_addr = 32'h0000_0304;
        #1;
        n_checks++;
        if (bus.ld_stall !== 1'b0) begin n_fail++; $display("FAIL ld_miss: got %b want 0", bus.ld_stall); end
        bus.ld_addr = 32'h0000_0401;
        #1;
        n_checks++;
        if (bus.ld_stall !== 1'b1) begin n_fail++; $display("FAIL ld_hit_tail: got %b want 1", bus.ld_stall); end
        bus.ld_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.ld_stall !== 1'b0) begin n_fail++; $display("FAIL ld_invalid: got %b want 0", bus.ld_stall); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h0000_0302;
        #1;
        n_checks++;
        if (bus.ld_stall !== 1'b0) begin n_fail++; $display("FAIL ld_after_drain: got %b want 0", bus.ld_stall); end
        bus.ld_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int   sent;
        int   rx;
        int   cyc;
        logic rdy;
        logic accepted;
        sent = 0; rx = 0; cyc = 0; rdy = 1'b0;
        while ((sent < 10 || rx < 10) && cyc < 200) begin
            bus.mem_ready = rdy;
            if (sent < 10) drive_store(32'h0000_5000 + 32'(sent * 4), 32'hA500_0000 + 32'(sent), 4'b1111);
            else idle_store();
            #1;
            if (bus.mem_valid && bus.mem_ready) begin
                n_checks++;
                if (bus.mem_addr !== 32'h0000_5000 + 32'(rx * 4) || bus.mem_wdata !== 32'hA500_0000 + 32'(rx)) begin
                    n_fail++;
                    $display("FAIL wrap_rx[%0d]: got a=%h d=%h want %h/%h", rx, bus.mem_addr, bus.mem_wdata,
                             32'h0000_5000 + 32'(rx * 4), 32'hA500_0000 + 32'(rx));
                end
                rx++;
            end
            accepted = bus.st_valid && !bus.st_stall;
            tick();
            if (accepted) sent++;
            rdy = !rdy;
            cyc++;
        end
        idle_store();
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (cyc >= 200 || rx != 10 || bus.count !== 3'd0) begin
            n_fail++; $display("FAIL wrap_total: got rx=%0d count=%0d cycles=%0d want 10/0/<200", rx, bus.count, cyc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_wdata  = '0;
        bus.st_byteen = 4'b0000;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_merge();
        test_load();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
